// File: rtl/percept_uart_rx_if.sv
// Strobe bundle from the UART front-end to the node's control/data stages.
// master drives data + strobes; slave consumes them with no backpressure.
interface percept_uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       pkt_start;
  logic       pkt_end;
  logic       frame_err;

  modport master (
    output data,
    output data_valid,
    output pkt_start,
    output pkt_end,
    output frame_err
  );

  modport slave (
    input data,
    input data_valid,
    input pkt_start,
    input pkt_end,
    input frame_err
  );
endinterface

// File: rtl/percept_uart_rx.sv
// 8N1 UART deframer with idle-gap packet delimiting and address filter.
// Ports: clk, rst (async high), address, rx in; pkt (master) strobes out.
module percept_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IDLE_BITS    = 12,
  parameter logic [7:0]  BCAST_ADDR   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic       rx,
  percept_uart_rx_if.master pkt
);

  localparam int unsigned HALF     = CLKS_PER_BIT / 2;
  localparam int unsigned IDLE_MAX = IDLE_BITS * CLKS_PER_BIT;
  localparam int          CW       = $clog2(CLKS_PER_BIT);
  localparam int          IW       = $clog2(IDLE_MAX + 1);

  typedef enum logic [1:0] {
    B_IDLE, B_START, B_DATA, B_STOP
  } bstate_t;

  typedef enum logic [1:0] {
    P_WAIT, P_ACCEPT, P_DROP
  } pstate_t;

  logic s1, s2, sp;
  logic rxs, fall;

  bstate_t bstate, bnext;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bitn, bit_n;
  logic [7:0] sh, sh_n;
  logic done, ferr;

  logic [IW-1:0] idle_cnt;
  logic idling, gap;

  pstate_t pstate, pnext;
  logic [7:0] data_r, data_n;
  logic dv_r, dv_n;
  logic ps_r, ps_n;
  logic pe_r, pe_n;
  logic fe_r, fe_n;
  logic hit;

  // sp is the previous synchronised sample, used only for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      sp <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      sp <= s2;
    end
  end

  assign rxs  = s2;
  assign fall = sp & ~s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bstate <= B_IDLE;
      cnt    <= '0;
      bitn   <= '0;
      sh     <= '0;
    end else begin
      bstate <= bnext;
      cnt    <= cnt_n;
      bitn   <= bit_n;
      sh     <= sh_n;
    end
  end

  always_comb begin
    bnext = bstate;
    cnt_n = cnt;
    bit_n = bitn;
    sh_n  = sh;
    done  = 1'b0;
    ferr  = 1'b0;
    unique case (bstate)
      B_IDLE: begin
        if (fall) begin
          bnext = B_START;
          cnt_n = '0;
        end
      end
      B_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n = '0;
          bit_n = '0;
          bnext = rxs ? B_IDLE : B_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n = '0;
          sh_n  = {rxs, sh[7:1]};
          bit_n = bitn + 3'd1;
          if (bitn == 3'd7) bnext = B_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_n = '0;
          bnext = B_IDLE;
          done  = rxs;
          ferr  = ~rxs;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: bnext = B_IDLE;
    endcase
  end

  // Starts saturated so the first byte after reset counts as a header
  assign idling = (bstate == B_IDLE) && rxs;
  assign gap    = idling && (idle_cnt == IW'(IDLE_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= IW'(IDLE_MAX);
    end else if (!idling) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IW'(IDLE_MAX)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign hit = (sh == address) || (sh == BCAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate <= P_WAIT;
      data_r <= '0;
      dv_r   <= 1'b0;
      ps_r   <= 1'b0;
      pe_r   <= 1'b0;
      fe_r   <= 1'b0;
    end else begin
      pstate <= pnext;
      data_r <= data_n;
      dv_r   <= dv_n;
      ps_r   <= ps_n;
      pe_r   <= pe_n;
      fe_r   <= fe_n;
    end
  end

  // done, ferr and gap are mutually exclusive, so at most one strobe
  always_comb begin
    pnext  = pstate;
    data_n = data_r;
    dv_n   = 1'b0;
    ps_n   = 1'b0;
    pe_n   = 1'b0;
    fe_n   = ferr;
    unique case (pstate)
      P_WAIT: begin
        if (done) begin
          pnext = hit ? P_ACCEPT : P_DROP;
          ps_n  = hit;
        end
      end
      P_ACCEPT: begin
        if (done) begin
          data_n = sh;
          dv_n   = 1'b1;
        end else if (gap) begin
          pe_n  = 1'b1;
          pnext = P_WAIT;
        end
      end
      P_DROP: begin
        if (gap) pnext = P_WAIT;
      end
      default: pnext = P_WAIT;
    endcase
  end

  assign pkt.data       = data_r;
  assign pkt.data_valid = dv_r;
  assign pkt.pkt_start  = ps_r;
  assign pkt.pkt_end    = pe_r;
  assign pkt.frame_err  = fe_r;

endmodule

// File: tb/tb_percept_uart_rx.sv
// Directed bench for percept_uart_rx at CLKS_PER_BIT=4, IDLE_BITS=12.
// Strobes are logged on negedge and checked against hand-derived counts.
module tb_percept_uart_rx;

  logic       clk;
  logic       rst;
  logic [7:0] address;
  logic       rx;

  percept_uart_rx_if u_if ();

  percept_uart_rx #(
    .CLKS_PER_BIT(4),
    .IDLE_BITS   (12),
    .BCAST_ADDR  (8'hFF)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .address(address),
    .rx     (rx),
    .pkt    (u_if)
  );

  int total;
  int bad;
  int n_dv, n_ps, n_pe, n_fe, n_excl;
  logic [7:0] dq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (u_if.data_valid) begin
      n_dv++;
      dq.push_back(u_if.data);
    end
    if (u_if.pkt_start) n_ps++;
    if (u_if.pkt_end)   n_pe++;
    if (u_if.frame_err) n_fe++;
    if (int'(u_if.data_valid) + int'(u_if.pkt_start)
        + int'(u_if.pkt_end) + int'(u_if.frame_err) > 1)
      n_excl++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    n_dv = 0;
    n_ps = 0;
    n_pe = 0;
    n_fe = 0;
    dq.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(4);
    end
    rx = stop;
    cyc(4);
    rx = 1'b1;
  endtask

  task automatic counts(input string t, input int ps, input int dv,
                        input int pe, input int fe);
    chk({t, ":start"}, n_ps, ps);
    chk({t, ":valid"}, n_dv, dv);
    chk({t, ":end"},   n_pe, pe);
    chk({t, ":ferr"},  n_fe, fe);
  endtask

  task automatic dat(input string t, input int idx, input logic [7:0] e);
    if (idx < dq.size()) chk(t, {24'h0, dq[idx]}, {24'h0, e});
    else                 chk(t, 32'hFFFF_FFFF, {24'h0, e});
  endtask

  task automatic outs_zero(input string t);
    chk({t, ":data"}, {24'h0, u_if.data}, 32'h0);
    chk({t, ":dv"},   {31'h0, u_if.data_valid}, 32'h0);
    chk({t, ":ps"},   {31'h0, u_if.pkt_start}, 32'h0);
    chk({t, ":pe"},   {31'h0, u_if.pkt_end}, 32'h0);
    chk({t, ":fe"},   {31'h0, u_if.frame_err}, 32'h0);
  endtask

  task automatic glitch();
    rx = 1'b0;
    cyc(1);
    rx = 1'b1;
  endtask

  initial begin
    logic [7:0] pb;
    total   = 0;
    bad     = 0;
    n_excl  = 0;
    clr();
    rx      = 1'b1;
    address = 8'h05;
    rst     = 1'b1;
    cyc(4);
    outs_zero("rst");
    rst = 1'b0;
    cyc(4);

    clr();
    send(8'h05, 1'b1);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    cyc(60);
    counts("t1", 1, 2, 1, 0);
    dat("t1:d0", 0, 8'hA5);
    dat("t1:d1", 1, 8'h3C);
    chk("t1:hold", {24'h0, u_if.data}, 32'h3C);

    clr();
    send(8'h07, 1'b1);
    send(8'h11, 1'b1);
    cyc(60);
    counts("t2a", 0, 0, 0, 0);
    clr();
    send(8'hFF, 1'b1);
    send(8'h22, 1'b1);
    cyc(60);
    counts("t2b", 1, 1, 1, 0);
    dat("t2b:d0", 0, 8'h22);

    clr();
    send(8'h05, 1'b1);
    send(8'h99, 1'b0);
    cyc(8);
    send(8'h44, 1'b1);
    cyc(60);
    counts("t3", 1, 1, 1, 1);
    dat("t3:d0", 0, 8'h44);

    clr();
    cyc(20);
    glitch();
    cyc(10);
    counts("t4a", 0, 0, 0, 0);
    clr();
    send(8'h05, 1'b1);
    cyc(30);
    glitch();
    cyc(30);
    send(8'h33, 1'b1);
    cyc(60);
    counts("t4b", 1, 1, 1, 0);
    dat("t4b:d0", 0, 8'h33);

    send(8'h05, 1'b1);
    pb = 8'h5A;
    rx = 1'b0;
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      cyc(4);
    end
    rx = pb[4];
    cyc(2);
    clr();
    rst = 1'b1;
    rx  = 1'b1;
    cyc(3);
    outs_zero("t5rst");
    cyc(2);
    rst = 1'b0;
    counts("t5a", 0, 0, 0, 0);
    cyc(10);
    send(8'h05, 1'b1);
    send(8'h01, 1'b1);
    cyc(60);
    counts("t5b", 1, 1, 1, 0);
    dat("t5b:d0", 0, 8'h01);

    clr();
    send(8'h05, 1'b1);
    cyc(40);
    send(8'h77, 1'b1);
    cyc(60);
    counts("t6a", 1, 1, 1, 0);
    dat("t6a:d0", 0, 8'h77);
    clr();
    send(8'h05, 1'b1);
    cyc(48);
    send(8'hFF, 1'b1);
    cyc(60);
    counts("t6b", 2, 0, 2, 0);

    chk("excl", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/percept_uart_rx.md
Name: percept_uart_rx

Overview:
Serial front-end for the perceptron node. It sits directly upstream of the node's control and data stages. It oversamples the shared rx line, deframes 8N1 UART characters and delimits packets by line-idle gaps. Only payload bytes of packets whose header byte matches this node's address (or broadcast) are forwarded, as single-cycle byte strobes.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit; legal range 4..65535.
IDLE_BITS, 12, count of consecutive idle bit-times on rx that terminates a packet.
BCAST_ADDR, 8'hFF, header value accepted by every node.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
address  input  8  this node's address; sampled at each header byte, may change between packets
rx  input  1  asynchronous serial line, idle high
data  output  8  payload byte; held stable until the next strobe
data_valid  output  1  one-cycle strobe; data is a payload byte of an accepted packet
pkt_start  output  1  one-cycle strobe when an accepted header is received
pkt_end  output  1  one-cycle strobe when an accepted packet is closed by the idle gap
frame_err  output  1  one-cycle strobe when a stop bit is sampled low

Behaviour:
- Reset (async assert, sync release): all outputs 0. Bit FSM in IDLE. Packet FSM in WAIT_HDR. Counters 0. Synchroniser flops set to 1.
- rx passes through a 2-flop synchroniser. All references below are to the synchronised signal (2-cycle input latency).
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge (synchronised rx goes 1->0).
  - START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample. If low -> DATA with the bit counter cleared. If high -> glitch; return to IDLE with no strobe.
  - DATA: sample every CLKS_PER_BIT cycles. Bits are LSB first into a shift register. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If high -> byte complete. If low -> frame_err strobe and the byte is discarded. Either way, return to IDLE in the same cycle.
  - A new falling edge is not searched for until the bit FSM is back in IDLE.
- Byte-complete strobe occurs exactly on the stop-sample cycle. The output strobe follows one cycle later (registered).
- Idle counter:
  - Counts clk cycles while the bit FSM is in IDLE and rx is high.
  - Cleared by any rx low or by any bit FSM state other than IDLE.
  - Saturates at IDLE_BITS*CLKS_PER_BIT and asserts gap for exactly one cycle on reaching it.
  - Reset sets it saturated, so the first byte after reset is treated as a header.
- Packet FSM states: WAIT_HDR, ACCEPT, DROP.
  - WAIT_HDR, byte complete: if the byte equals address or BCAST_ADDR -> ACCEPT with a pkt_start strobe. Otherwise -> DROP.
  - ACCEPT, byte complete: data <= byte and a data_valid strobe.
  - ACCEPT, gap: pkt_end strobe -> WAIT_HDR.
  - DROP, byte complete: ignored. DROP, gap: -> WAIT_HDR, no strobe.
  - WAIT_HDR, gap: no action.
  - A byte received in WAIT_HDR without a preceding gap cannot occur, because WAIT_HDR is only entered on a gap or at reset.
- frame_err in any packet state: strobe is issued and the packet FSM state is unchanged (the error does not terminate the packet).
- A byte complete and a gap cannot coincide, because the idle counter is cleared during reception.
- data_valid, pkt_start, pkt_end and frame_err are mutually exclusive in any cycle.
- Output latency: data_valid asserts 1 clk after the stop-bit sample point. Downstream has no backpressure and must accept every strobe.
- Reset asserted mid-character or mid-packet: the partial byte is discarded, no strobes are issued, and the next byte is treated as a header.
- Counters are sized for the maximum CLKS_PER_BIT and IDLE_BITS; no wrap is permitted below saturation.

Test Plan:
- CLKS_PER_BIT=4, IDLE_BITS=12, address=8'h05. Send 0x05, 0xA5, 0x3C back-to-back, then hold rx high 48 cycles -> pkt_start after byte 1; data_valid with data=0xA5 then 0x3C; one pkt_end strobe.
- address=8'h05. Send 0x07, 0x11, then idle, then 0xFF, 0x22 -> no strobes for the first packet; second packet gives pkt_start and data_valid with 0x22.
- Send 0x05, then 0x99 with a low stop bit -> frame_err strobe; no data_valid for 0x99; the packet stays accepted and a following 0x44 yields data_valid with 0x44.
- rx low pulse of 1 cycle while idle -> no strobes; the bit FSM returns to IDLE and the idle counter restarts from 0.
- Assert rst during bit 4 of a payload byte, release, idle 10 cycles, send 0x05, 0x01 -> no strobes before release; after release 0x05 is taken as a header; data_valid with 0x01.
- Send 0x05 and payload separated by a 40-cycle gap (less than 48) -> the payload is still accepted. Repeat with a 48-cycle gap -> pkt_end; the payload byte is treated as a header.
